// File: rtl/seg_scan_drv.sv
// Six-digit common-anode display driver: sequential double-dabble conversion of a saturated
// 20-bit value, then time-multiplexed scan with leading-zero blanking and decimal points.
module seg_scan_drv #(
    parameter logic [15:0] SCAN_DIV = 16'd50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        en,
    output logic [5:0]  sel,
    output logic [7:0]  seg_led
);
    localparam logic [19:0] MaxVal = 20'd999_999;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e      state;
    logic [19:0] data_sat;
    logic [19:0] last_val;
    logic [19:0] bin;
    logic [23:0] acc;
    logic [23:0] acc_adj;
    logic [23:0] bcd;
    logic [4:0]  bit_cnt;
    logic [15:0] cnt;
    logic [2:0]  idx;

    assign data_sat = (data > MaxVal) ? MaxVal : data;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 6; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // The display register only changes in StDone, so it never holds a partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            last_val <= '0;
            bin      <= '0;
            acc      <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (data_sat != last_val) begin
                        last_val <= data_sat;
                        bin      <= data_sat;
                        acc      <= '0;
                        bit_cnt  <= '0;
                        state    <= StConv;
                    end
                end
                StConv: begin
                    acc     <= {acc_adj[22:0], bin[19]};
                    bin     <= {bin[18:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd19) state <= StDone;
                end
                StDone: begin
                    bcd   <= acc;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == SCAN_DIV - 16'd1) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    logic [3:0]  digit;
    logic        dp;
    logic        blank;
    logic [23:0] upper;
    logic [6:0]  seg_dec;
    logic [5:0]  sel_d;
    logic [7:0]  seg_d;

    always_comb begin
        digit = 4'd0;
        dp    = 1'b0;
        unique case (idx)
            3'd0:    begin digit = bcd[3:0];   dp = point[0]; end
            3'd1:    begin digit = bcd[7:4];   dp = point[1]; end
            3'd2:    begin digit = bcd[11:8];  dp = point[2]; end
            3'd3:    begin digit = bcd[15:12]; dp = point[3]; end
            3'd4:    begin digit = bcd[19:16]; dp = point[4]; end
            3'd5:    begin digit = bcd[23:20]; dp = point[5]; end
            default: begin digit = 4'd0;       dp = 1'b0;     end
        endcase

        // Digit k is a leading zero when it and every nibble above it are zero.
        upper = bcd >> {idx, 2'b00};
        blank = (idx != 3'd0) && (upper == 24'd0);

        unique case (digit)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h7F;
        endcase

        if (en) begin
            sel_d = ~(6'b000001 << idx);
            seg_d = {~dp, blank ? 7'h7F : seg_dec};
        end else begin
            sel_d = 6'h3F;
            seg_d = 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= 6'h3F;
            seg_led <= 8'hFF;
        end else begin
            sel     <= sel_d;
            seg_led <= seg_d;
        end
    end
endmodule
